// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, least significant digit first.
// Negative differences are re-complemented in a second serial pass (FIX).
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                neg,
  output logic                err,
  output logic                busy,
  output logic                done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IW-1:0]       i_q, i_d;
  logic                mode_q, mode_d, c_q, c_d;
  logic                cout_q, cout_d, neg_q, neg_d, err_q, err_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic                in_bad, last;
  logic [3:0]          op_x, op_y, dig;
  logic [4:0]          t;
  logic                c_nxt;

  always_comb begin
    in_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) in_bad = 1'b1;
  end

  // One shared digit adder: CALC adds a_i + (b_i or 9-b_i), FIX adds 9-r_i.
  always_comb begin
    if (state_q == FIX) begin
      op_x = 4'd9 - res_q[4*i_q +: 4];
      op_y = 4'd0;
    end else begin
      op_x = a_q[4*i_q +: 4];
      op_y = mode_q ? 4'd9 - b_q[4*i_q +: 4] : b_q[4*i_q +: 4];
    end
    t = {1'b0, op_x} + {1'b0, op_y} + {4'd0, c_q};
    if (t > 5'd9) begin
      dig   = 4'(t + 5'd6);
      c_nxt = 1'b1;
    end else begin
      dig   = t[3:0];
      c_nxt = 1'b0;
    end
    last = (i_q == IW'(DIGITS - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    i_d     = i_q;
    mode_d  = mode_q;
    c_d     = c_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        mode_d  = mode;
        res_d   = '0;
        cout_d  = 1'b0;
        neg_d   = 1'b0;
        err_d   = in_bad;
        i_d     = '0;
        c_d     = mode;
        busy_d  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        if (err_q) begin
          state_d = DONE;
        end else begin
          res_d[4*i_q +: 4] = dig;
          c_d = c_nxt;
          i_d = i_q + 1'b1;
          if (last) begin
            i_d = '0;
            if (!mode_q) begin
              cout_d  = c_nxt;
              state_d = DONE;
            end else if (c_nxt) begin
              neg_d   = 1'b0;
              state_d = DONE;
            end else begin
              neg_d   = 1'b1;
              c_d     = 1'b1;
              state_d = FIX;
            end
          end
        end
      end
      FIX: begin
        res_d[4*i_q +: 4] = dig;
        c_d = c_nxt;
        i_d = i_q + 1'b1;
        if (last) begin
          i_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle raises done; second returns to IDLE, so start is
        // never accepted at the edge that ends the done pulse.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      i_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign neg    = neg_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench: driver pushes integer-model expectations, monitor pops on done.
module tb_bcd_addsub_serial;
  localparam int D = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, mode = 1'b0;
  logic [15:0] a = '0, b = '0, result;
  logic        cout, neg, err, busy, done;

  logic        s1_start = 1'b0, s1_mode = 1'b0;
  logic [3:0]  s1_a = '0, s1_b = '0, s1_result;
  logic        s1_cout, s1_neg, s1_err, s1_busy, s1_done;

  int cyc = 0;
  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [15:0] res;
    logic        cout, neg, err;
    int          done_cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t me;

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .result(result), .cout(cout), .neg(neg), .err(err), .busy(busy), .done(done));

  bcd_addsub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .mode(s1_mode), .a(s1_a), .b(s1_b),
    .result(s1_result), .cout(s1_cout), .neg(s1_neg), .err(s1_err), .busy(s1_busy),
    .done(s1_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit is_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    int p;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 15) == 0) begin
      p = int'($urandom_range(0, 3));
      r[4*p +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        me = sbq.pop_front();
        chk("result", 32'(result), 32'(me.res));
        chk("cout", 32'(cout), 32'(me.cout));
        chk("neg", 32'(neg), 32'(me.neg));
        chk("err", 32'(err), 32'(me.err));
        chk("done_cycle", cyc, me.done_cyc);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout", 32'(busy | done), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  // (or after an optional start pulse pulse_at cycles later).
  task automatic do_op(input logic m, input logic [15:0] av, input logic [15:0] bv,
                       input int pulse_at);
    exp_t e;
    int   ai, bi, s, lat;
    wait_idle();
    ai = bcd2int(av);
    bi = bcd2int(bv);
    e.cout = 1'b0; e.neg = 1'b0; e.err = 1'b0;
    if (is_bad(av) || is_bad(bv)) begin
      e.res = '0; e.err = 1'b1; lat = 2;
    end else if (!m) begin
      s = ai + bi;
      e.res = int2bcd(s % 10000); e.cout = (s >= 10000); lat = D + 1;
    end else if (ai >= bi) begin
      e.res = int2bcd(ai - bi); lat = D + 1;
    end else begin
      e.res = int2bcd(bi - ai); e.neg = 1'b1; lat = 2 * D + 1;
    end
    e.done_cyc = cyc + 1 + lat;
    sbq.push_back(e);
    start = 1'b1; mode = m; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); mode = ~m;
    chk("busy_on_accept", 32'(busy), 32'd1);
    @(negedge clk);
    if (pulse_at > 0) begin
      repeat (pulse_at - 1) @(negedge clk);
      start = 1'b1; a = 16'h0001; b = 16'h0002;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_in_done();
    int n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("done_timeout", 32'(done), 32'd1);
    start = 1'b1; mode = 1'b0; a = 16'h0011; b = 16'h0022;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_op1(input logic m, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] er, input logic ec, input logic en, input int lat);
    int k, n;
    s1_start = 1'b1; s1_mode = m; s1_a = av; s1_b = bv;
    k = cyc + 1;
    @(posedge clk); #1 s1_start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s1_done && n < 50) begin @(negedge clk); n++; end
    chk("d1_result", 32'(s1_result), 32'(er));
    chk("d1_cout", 32'(s1_cout), 32'(ec));
    chk("d1_neg", 32'(s1_neg), 32'(en));
    chk("d1_done_cycle", cyc, k + lat);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    do_op(1'b0, 16'h1234, 16'h8766, 0);
    do_op(1'b0, 16'h0999, 16'h0001, 0);
    do_op(1'b1, 16'h5000, 16'h1234, 0);
    do_op(1'b1, 16'h4321, 16'h4321, 0);
    do_op(1'b1, 16'h1234, 16'h5000, 7);
    do_op(1'b0, 16'h12A4, 16'h0001, 0);
    do_op(1'b0, 16'h9999, 16'h9999, 0);
    do_op(1'b1, 16'h0000, 16'h9999, 0);
    do_op(1'b0, 16'h0001, 16'h0002, 0);
    pulse_in_done();

    // Abort mid-CALC: no done may follow (monitor flags any).
    wait_idle();
    start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_still_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 150; i++)
      do_op(1'($urandom_range(0, 1)), rand_bcd(), rand_bcd(), 0);

    do_op1(1'b1, 4'd3, 4'd7, 4'd4, 1'b0, 1'b1, 3);
    do_op1(1'b0, 4'd5, 4'd7, 4'd2, 1'b1, 1'b0, 2);
    do_op1(1'b1, 4'd7, 4'd3, 4'd4, 1'b0, 1'b0, 2);
    do_op1(1'b1, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 2);

    n = 0;
    while (sbq.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (sbq.size() != 0) chk("pending_at_end", 32'(sbq.size()), 32'd0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
